bit_stream_decoder: RTL
=======================

# bit_stream_decoder

Receive-side packet parser for the USB low-level path; the inverse of `bitStreamEncoder`. It consumes the NRZI-decoded, de-stuffed serial bit stream, hunts for SYNC, and extracts PID, address/endpoint, or 64-bit data payload. It checks the PID check-nibble, CRC5/CRC16 and packet length, then reports one result pulse per packet at EOP. It sits between the de-stuffer and the protocol FSM.

## Interface
- No parameters. Payload is fixed at 64 bits, matching the transmit path.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  de-stuffed, NRZI-decoded bit; sampled only when bit_valid=1.
- bit_valid  in  1  bit_in carries a real bit this cycle; 0 for stuffed-bit slots and idle.
- eop  in  1  single-cycle end-of-packet indication from the line receiver (SE0 detected).
- pkt_done  out  1  one-cycle pulse: packet finished and result fields valid.
- pid_out  out  8  received PID byte {check nibble, pid nibble}, e.g. 8'hE1 = OUT.
- addr_out  out  7  token address (tokens only, otherwise 0).
- endp_out  out  4  token endpoint (tokens only, otherwise 0).
- data_out  out  64  data payload (DATA0/DATA1 only, otherwise 0).
- pid_err  out  1  check nibble is not the complement, or PID is not one of OUT/IN/SETUP/DATA0/DATA1/ACK/NAK/STALL.
- crc_err  out  1  CRC residual mismatch.
- len_err  out  1  EOP at the wrong bit position for the PID type.
- busy  out  1  a SYNC has been matched and EOP has not yet arrived.

## Operation
- Wire order is LSB first for every field.
  - PID: pid_out[0] arrives first.
  - Token: addr[0..6], endp[0..3], crc5[4..0].
  - Data: data_out[0] arrives first and data_out[63] last, followed by crc16[15..0].
- States: IDLE, PID, TOKEN, DATA, CRC, TAIL, ERR.
- IDLE keeps an 8-bit shift history of valid bits. When the last 8 valid bits are 0,0,0,0,0,0,0,1 (oldest first), move to PID and set busy=1.
- PID: collect 8 bits. At the 8th bit, decode the type:
  - Token (OUT E1, IN 69, SETUP 2D): go to TOKEN, 11-bit count, then CRC with 5 bits.
  - Data (DATA0 C3, DATA1 4B): go to DATA, 64-bit count, then CRC with 16 bits.
  - Handshake (ACK D2, NAK 5A, STALL 1E): go to TAIL.
  - Invalid PID: set pid_err and go to ERR.
- CRC5 uses polynomial x^5+x^2+1, init 5'b11111, and runs over addr+endp+crc bits. After all 16 bits the remainder must equal 5'b01100.
- CRC16 uses polynomial x^16+x^15+x^2+1, init 16'hFFFF, and runs over data+crc bits. The remainder must equal 16'h800D.
- Mismatch at the last CRC bit sets crc_err. A mismatch does not stop parsing.
- TAIL: the packet body is complete. Any further valid bit before EOP sets len_err and moves to ERR.
- ERR: ignore bits and wait for EOP.
- EOP outside IDLE:
  - Pulse pkt_done.
  - Set len_err if the state is not TAIL and not ERR (in ERR, len_err is already set when ERR was entered from TAIL).
  - Return to IDLE and clear busy.
- EOP in IDLE (no SYNC matched) is ignored; there is no pkt_done.
- eop and bit_valid high in the same cycle: eop wins and the bit is discarded.
- Result registers (pid_out, addr_out, endp_out, data_out, error flags) are cleared when a SYNC match moves the block into PID. They are held stable from pkt_done until the next SYNC match.
- Address, endpoint and data fields are reported as received even when crc_err=1.

## Timing
- Reset (synchronous): state=IDLE, SYNC history cleared, all outputs 0 on the first edge with rst=1.
- Reset mid-packet aborts the packet with no pkt_done.
- One valid bit is consumed per clock at most. bit_valid gaps of any length are allowed anywhere, including inside SYNC.
- Latency: pkt_done rises on the edge after the cycle in which eop=1 is sampled. Result fields are valid in that same cycle.
- busy rises on the edge that consumes the final SYNC bit. busy falls together with the pkt_done pulse.
- Back-to-back packets: a new SYNC may start on the cycle immediately after the eop cycle.

## Test plan
- OUT token, addr 5, endp 4, generated by the bitStreamEncoder → de-stuffer path, then eop → single pkt_done with pid_out=E1, addr_out=5, endp_out=4, all error flags 0.
- DATA0 (C3) with payload 64'hCAFEBABEDEADBEEF and encoder CRC16, with random bit_valid gaps → data_out=CAFEBABEDEADBEEF, crc_err=0. Then flip data bit 17 → crc_err=1 and data_out shows the flipped value.
- ACK (D2) then eop → pid_out=D2, addr_out=0, data_out=0, no errors. ACK with one extra valid bit before eop → len_err=1.
- PID byte 8'hE0 → pid_err=1 at eop, no CRC check. Token truncated with eop after 6 body bits → len_err=1.
- eop with no preceding SYNC, and eop coinciding with bit_valid at the last CRC bit position → no pkt_done in the first case; len_err=1 in the second.
- rst asserted in the middle of DATA → all outputs 0 next cycle, no pkt_done. The following clean ACK decodes correctly.

Source files
------------

// File: rtl/bit_stream_decoder.sv
// bit_stream_decoder: receive-side USB packet parser. Hunts for SYNC in the
// de-stuffed bit stream, then extracts PID, token address/endpoint or a 64-bit
// data payload, checks the PID, the CRC5/CRC16 residual and the packet length,
// and pulses pkt_done once per packet at EOP.
module bit_stream_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        eop,
    output logic        pkt_done,
    output logic [7:0]  pid_out,
    output logic [6:0]  addr_out,
    output logic [3:0]  endp_out,
    output logic [63:0] data_out,
    output logic        pid_err,
    output logic        crc_err,
    output logic        len_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOKEN, S_DATA, S_CRC, S_TAIL, S_ERR
    } state_t;

    state_t      state, state_next;
    logic [6:0]  sync_hist;   // previous seven valid bits, newest in bit 0
    logic [6:0]  cnt;         // bit index inside the current field
    logic        is_data;     // selects CRC16 (data) or CRC5 (token)
    logic [15:0] crc;         // CRC5 lives in crc[4:0] for tokens

    logic        bit_take;
    logic        sync_hit;
    logic [7:0]  pid_byte;
    logic        pid_tok, pid_dat, pid_hs;
    logic [15:0] crc_next;
    logic [6:0]  crc_last;
    logic        crc_bad;

    // Serial CRC5 step, x^5+x^2+1, wire bits shifted in LSB-of-field first.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    // Serial CRC16 step, x^16+x^15+x^2+1.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    // Decode helpers shared by the FSM and the datapath; eop discards a coincident bit.
    always_comb begin
        bit_take = bit_valid & ~eop;
        sync_hit = (state == S_IDLE) && bit_take && ({sync_hist, bit_in} == 8'h01);
        pid_byte = {bit_in, pid_out[6:0]};
        pid_tok  = pid_byte inside {8'hE1, 8'h69, 8'h2D};
        pid_dat  = pid_byte inside {8'hC3, 8'h4B};
        pid_hs   = pid_byte inside {8'hD2, 8'h5A, 8'h1E};
        crc_next = is_data ? crc16_step(crc, bit_in)
                           : {11'b0, crc5_step(crc[4:0], bit_in)};
        crc_last = is_data ? 7'd15 : 7'd4;
        crc_bad  = is_data ? (crc_next != 16'h800D) : (crc_next[4:0] != 5'b01100);
    end

    // Next-state logic; EOP anywhere outside IDLE ends the packet.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (sync_hit) state_next = S_PID;
            S_PID:   if (bit_take && cnt == 7'd7) begin
                         if (pid_tok)      state_next = S_TOKEN;
                         else if (pid_dat) state_next = S_DATA;
                         else if (pid_hs)  state_next = S_TAIL;
                         else              state_next = S_ERR;
                     end
            S_TOKEN: if (bit_take && cnt == 7'd10) state_next = S_CRC;
            S_DATA:  if (bit_take && cnt == 7'd63) state_next = S_CRC;
            S_CRC:   if (bit_take && cnt == crc_last) state_next = S_TAIL;
            S_TAIL:  if (bit_take) state_next = S_ERR;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
        if (eop && state != S_IDLE) state_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Field bit counter: restarts on every state change, advances per consumed bit.
    always_ff @(posedge clk) begin
        if (rst)                      cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (bit_take)            cnt <= cnt + 7'd1;
    end

    // Datapath: SYNC history, field capture, CRC, error flags and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_hist <= '0;
            is_data   <= 1'b0;
            crc       <= '0;
            pkt_done  <= 1'b0;
            pid_out   <= '0;
            addr_out  <= '0;
            endp_out  <= '0;
            data_out  <= '0;
            pid_err   <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (eop) begin
                if (state != S_IDLE) begin
                    pkt_done  <= 1'b1;
                    busy      <= 1'b0;
                    sync_hist <= '0;
                    if (state != S_TAIL && state != S_ERR) len_err <= 1'b1;
                end
            end else if (bit_take) begin
                case (state)
                    S_IDLE: begin
                        sync_hist <= {sync_hist[5:0], bit_in};
                        if (sync_hit) begin
                            sync_hist <= '0;
                            busy      <= 1'b1;
                            pid_out   <= '0;
                            addr_out  <= '0;
                            endp_out  <= '0;
                            data_out  <= '0;
                            pid_err   <= 1'b0;
                            crc_err   <= 1'b0;
                            len_err   <= 1'b0;
                        end
                    end
                    S_PID: begin
                        pid_out[cnt[2:0]] <= bit_in;
                        if (cnt == 7'd7) begin
                            is_data <= pid_dat;
                            crc     <= pid_dat ? 16'hFFFF : 16'h001F;
                            if (!(pid_tok || pid_dat || pid_hs)) pid_err <= 1'b1;
                        end
                    end
                    S_TOKEN: begin
                        if (cnt < 7'd7) addr_out[cnt[2:0]] <= bit_in;
                        else            endp_out[cnt[1:0] + 2'd1] <= bit_in;
                        crc <= crc_next;
                    end
                    S_DATA: begin
                        data_out[cnt[5:0]] <= bit_in;
                        crc <= crc_next;
                    end
                    S_CRC: begin
                        crc <= crc_next;
                        if (cnt == crc_last && crc_bad) crc_err <= 1'b1;
                    end
                    S_TAIL:  len_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
